// File: rtl/serial_alu_pkg.sv
// rtl/serial_alu_pkg.sv - shared types and encodings for the bit-serial ALU sequencer
//
// Contents: sequencer state enum, 2-bit slice op encodings, and the 4-bit
// ALU control words {a_invert, b_invert, op[1:0]} for the common operations.

package serial_alu_pkg;

    typedef enum logic [1:0] {
        ST_IDLE     = 2'd0,
        ST_RUN      = 2'd1,
        ST_SLT_PASS = 2'd2,
        ST_DONE     = 2'd3
    } state_t;

    localparam logic [1:0] OP_AND = 2'b00;
    localparam logic [1:0] OP_OR  = 2'b01;
    localparam logic [1:0] OP_ADD = 2'b10;
    localparam logic [1:0] OP_SLT = 2'b11;

    localparam logic [3:0] CTL_AND = 4'b0000;
    localparam logic [3:0] CTL_OR  = 4'b0001;
    localparam logic [3:0] CTL_ADD = 4'b0010;
    localparam logic [3:0] CTL_SUB = 4'b0110;
    localparam logic [3:0] CTL_SLT = 4'b0111;
    localparam logic [3:0] CTL_NOR = 4'b1100;

endpackage

// File: rtl/serial_alu_if.sv
// rtl/serial_alu_if.sv - request/response bus of the bit-serial ALU sequencer
//
// Signals: in_valid/in_ready/a/b/alu_ctl (request), out_valid/out_ready/
// result/zero/overflow/carry_out (response).
// master: the requester (drives requests, accepts results).
// slave : the sequencer.

interface serial_alu_if #(
    parameter int WIDTH = 8
) ();

    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic [3:0]       alu_ctl;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] result;
    logic             zero;
    logic             overflow;
    logic             carry_out;

    modport master (
        output in_valid, a, b, alu_ctl, out_ready,
        input  in_ready, out_valid, result, zero, overflow, carry_out
    );

    modport slave (
        input  in_valid, a, b, alu_ctl, out_ready,
        output in_ready, out_valid, result, zero, overflow, carry_out
    );

endinterface

// File: rtl/serial_alu_ctrl.sv
// rtl/serial_alu_ctrl.sv - bit-serial sequencer driving an external 1-bit ALU slice
//
// Ports:
//   clk, rst        clock, synchronous active-high reset
//   bus (slave)     request/response handshake, operands, result and flags
//   slice_a/b       current operand bits (LSB first)
//   slice_a_invert, slice_b_invert, slice_carry_in, slice_less, slice_op
//                   controls to the slice
//   slice_result, slice_carry  combinational slice outputs, sampled every edge
//
// An operation takes WIDTH edges (AND/OR/ADD) or 2*WIDTH edges (SLT: one
// subtract pass to find the sign, then a pass feeding it into bit 0 via Less).

module serial_alu_ctrl
    import serial_alu_pkg::*;
#(
    parameter int WIDTH = 8
) (
    input  logic          clk,
    input  logic          rst,
    serial_alu_if.slave   bus,
    output logic          slice_a,
    output logic          slice_b,
    output logic          slice_less,
    output logic          slice_a_invert,
    output logic          slice_b_invert,
    output logic          slice_carry_in,
    output logic [1:0]    slice_op,
    input  logic          slice_result,
    input  logic          slice_carry
);

    localparam int CW = (WIDTH > 2) ? $clog2(WIDTH) : 1;
    localparam logic [CW-1:0] CNT_LAST = CW'(WIDTH - 1);

    state_t           state;
    logic [WIDTH-1:0] a_q;
    logic [WIDTH-1:0] b_q;
    logic             ainv_q;
    logic             binv_q;
    logic [1:0]       op_q;
    logic             carry_q;
    logic [CW-1:0]    cnt;
    logic [WIDTH-1:0] res_q;
    logic             lt_q;
    logic             ovf_q;
    logic             cout_q;
    logic             zero_q;
    logic             out_valid_q;

    logic [WIDTH-1:0] res_next;
    logic             last_bit;
    logic             ovf_now;

    assign res_next = {slice_result, res_q[WIDTH-1:1]};
    assign last_bit = (cnt == CNT_LAST);
    // Signed overflow: carry into the MSB differs from carry out of it.
    assign ovf_now  = carry_q ^ slice_carry;

    assign bus.in_ready  = (state == ST_IDLE) && !rst;
    assign bus.out_valid = out_valid_q;
    assign bus.result    = res_q;
    assign bus.zero      = zero_q;
    assign bus.overflow  = ovf_q;
    assign bus.carry_out = cout_q;

    always_comb begin
        slice_a        = 1'b0;
        slice_b        = 1'b0;
        slice_less     = 1'b0;
        slice_a_invert = 1'b0;
        slice_b_invert = 1'b0;
        slice_carry_in = 1'b0;
        slice_op       = OP_AND;
        case (state)
            ST_RUN: begin
                slice_a        = a_q[cnt];
                slice_b        = b_q[cnt];
                slice_a_invert = ainv_q;
                slice_b_invert = binv_q;
                slice_carry_in = carry_q;
                // SLT's first pass is a plain subtraction to obtain the sign.
                slice_op       = (op_q == OP_SLT) ? OP_ADD : op_q;
            end
            ST_SLT_PASS: begin
                slice_a        = a_q[cnt];
                slice_b        = b_q[cnt];
                slice_a_invert = ainv_q;
                slice_b_invert = binv_q;
                slice_op       = OP_SLT;
                slice_less     = (cnt == '0) ? lt_q : 1'b0;
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= ST_IDLE;
            a_q         <= '0;
            b_q         <= '0;
            ainv_q      <= 1'b0;
            binv_q      <= 1'b0;
            op_q        <= OP_AND;
            carry_q     <= 1'b0;
            cnt         <= '0;
            res_q       <= '0;
            lt_q        <= 1'b0;
            ovf_q       <= 1'b0;
            cout_q      <= 1'b0;
            zero_q      <= 1'b0;
            out_valid_q <= 1'b0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (bus.in_valid) begin
                        a_q     <= bus.a;
                        b_q     <= bus.b;
                        ainv_q  <= bus.alu_ctl[3];
                        binv_q  <= bus.alu_ctl[2];
                        op_q    <= bus.alu_ctl[1:0];
                        // b_invert doubles as the +1 of two's-complement negation.
                        carry_q <= bus.alu_ctl[2];
                        cnt     <= '0;
                        state   <= ST_RUN;
                    end
                end
                ST_RUN: begin
                    carry_q <= slice_carry;
                    res_q   <= res_next;
                    zero_q  <= (res_next == '0);
                    cnt     <= cnt + 1'b1;
                    if (last_bit) begin
                        if (op_q == OP_AND || op_q == OP_OR) begin
                            ovf_q  <= 1'b0;
                            cout_q <= 1'b0;
                        end else begin
                            ovf_q  <= ovf_now;
                            cout_q <= slice_carry;
                        end
                        // True sign of a-b, corrected for overflow.
                        lt_q <= slice_result ^ ovf_now;
                        cnt  <= '0;
                        if (op_q == OP_SLT) begin
                            state <= ST_SLT_PASS;
                        end else begin
                            state       <= ST_DONE;
                            out_valid_q <= 1'b1;
                        end
                    end
                end
                ST_SLT_PASS: begin
                    res_q  <= res_next;
                    zero_q <= (res_next == '0);
                    cnt    <= cnt + 1'b1;
                    if (last_bit) begin
                        cnt         <= '0;
                        state       <= ST_DONE;
                        out_valid_q <= 1'b1;
                    end
                end
                ST_DONE: begin
                    if (bus.out_ready) begin
                        state       <= ST_IDLE;
                        out_valid_q <= 1'b0;
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

endmodule
